// File: rtl/seg7_frame_feeder_pkg.sv
// -----------------------------------------------------------------------------
// seg7_frame_feeder_pkg
// Shared definitions for the 7-segment frame feeder: segment patterns, the
// scan FSM state encoding and the BCD-to-segment lookup.
// Segment byte layout: bit0 = a ... bit6 = g, bit7 = dp (active-high, before
// any common-anode inversion).
// -----------------------------------------------------------------------------
package seg7_frame_feeder_pkg;

  localparam logic [7:0] SEG_OFF  = 8'h00;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_DP   = 8'h80;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_e;

  // Digits 0..9 map to their glyphs; any other nibble shows a dash so that
  // corrupted countdown data is visible rather than silently looking like a digit.
  function automatic logic [7:0] bcd_to_seg7(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_frame_feeder_if.sv
// -----------------------------------------------------------------------------
// seg7_frame_feeder_if
// Bundles the feeder's data/strobe inputs and its driver-facing outputs.
//   digit_bcd   : BCD digits, [3:0] least significant
//   dp_mask     : decimal point enable per digit
//   blank       : level, 1 = display off
//   load        : 1-cycle pulse, capture digit_bcd/dp_mask
//   frame_tick  : 1-cycle pulse at each 595 refresh boundary
//   o_buf       : segment byte to the 74HC595 driver
//   o_digit_sel : one-hot digit enable
//   o_frame_cnt : wrapping count of applied frames
// master = producer of digits/strobes, slave = the feeder itself.
// -----------------------------------------------------------------------------
interface seg7_frame_feeder_if #(
  parameter int NUM_DIGITS = 2
);
  logic [4*NUM_DIGITS-1:0] digit_bcd;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank;
  logic                    load;
  logic                    frame_tick;
  logic [7:0]              o_buf;
  logic [NUM_DIGITS-1:0]   o_digit_sel;
  logic [7:0]              o_frame_cnt;

  modport master (
    output digit_bcd, dp_mask, blank, load, frame_tick,
    input  o_buf, o_digit_sel, o_frame_cnt
  );

  modport slave (
    input  digit_bcd, dp_mask, blank, load, frame_tick,
    output o_buf, o_digit_sel, o_frame_cnt
  );
endinterface

// File: rtl/seg7_frame_feeder_lzb_decode.sv
// -----------------------------------------------------------------------------
// seg7_frame_feeder_lzb_decode
// Combinational: picks digit idx_i out of the committed digits and produces
// its raw (non-inverted) segment byte, including decimal point and optional
// leading-zero blanking.
//   digits_i : committed BCD digits
//   dp_i     : committed decimal point mask
//   idx_i    : digit being displayed
//   seg_o    : raw segment byte
// -----------------------------------------------------------------------------
module seg7_frame_feeder_lzb_decode
  import seg7_frame_feeder_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int LZ_BLANK   = 1,
  parameter int IDX_W      = 1
) (
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [IDX_W-1:0]        idx_i,
  output logic [7:0]              seg_o
);

  logic [3:0] nib_s;
  logic       lz_s;
  logic [7:0] glyph_s;

  // A digit above the LSD is blanked only when it and every higher digit are
  // literal zero; an invalid nibble counts as non-zero, so it stops blanking.
  always_comb begin
    nib_s = digits_i[idx_i*4 +: 4];
    lz_s  = (LZ_BLANK != 0) && (idx_i != {IDX_W{1'b0}});
    for (int j = 0; j < NUM_DIGITS; j++) begin
      lz_s = lz_s && !((j >= int'(idx_i)) && (digits_i[j*4 +: 4] != 4'd0));
    end
    glyph_s = lz_s ? SEG_OFF : bcd_to_seg7(nib_s);
    seg_o   = glyph_s | (dp_i[idx_i] ? SEG_DP : SEG_OFF);
  end

endmodule

// File: rtl/seg7_frame_feeder.sv
// -----------------------------------------------------------------------------
// seg7_frame_feeder
// Upstream feeder for the 74HC595 serial driver. Holds NUM_DIGITS BCD digits
// and time-multiplexes them into the driver's parallel byte, changing outputs
// only on frame_tick so each shifted frame carries one consistent pattern.
//   clk   : system clock
//   rst_n : async active-low reset
//   bus   : seg7_frame_feeder_if.slave (digits, strobes, driver outputs)
// Buffering: load -> shadow; frame_tick -> shadow copied to committed and the
// registered outputs recomputed from that new committed value.
// Scan: a frame on which the FSM leaves BLANK is still shown dark; digit 0
// appears from the following frame and each digit holds HOLD_FRAMES frames.
// -----------------------------------------------------------------------------
module seg7_frame_feeder
  import seg7_frame_feeder_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int HOLD_FRAMES  = 4,
  parameter int COMMON_ANODE = 0,
  parameter int LZ_BLANK     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_frame_feeder_if.slave bus
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [7:0] BUF_INV = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_INV =
    (COMMON_ANODE != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] comm_bcd_q, comm_bcd_d;
  logic [NUM_DIGITS-1:0]   comm_dp_q, comm_dp_d;
  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [7:0]              buf_q, buf_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              seg_s;
  logic                    show_s;

  // Decode from the value being committed this cycle, not the stale one.
  seg7_frame_feeder_lzb_decode #(
    .NUM_DIGITS (NUM_DIGITS),
    .LZ_BLANK   (LZ_BLANK),
    .IDX_W      (IDX_W)
  ) u_decode (
    .digits_i (comm_bcd_d),
    .dp_i     (comm_dp_d),
    .idx_i    (idx_q),
    .seg_o    (seg_s)
  );

  // State, buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_bcd_q <= {4*NUM_DIGITS{1'b0}};
      shadow_dp_q  <= {NUM_DIGITS{1'b0}};
      comm_bcd_q   <= {4*NUM_DIGITS{1'b0}};
      comm_dp_q    <= {NUM_DIGITS{1'b0}};
      state_q      <= ST_BLANK;
      idx_q        <= {IDX_W{1'b0}};
      hold_q       <= {HOLD_W{1'b0}};
      buf_q        <= SEG_OFF ^ BUF_INV;
      sel_q        <= SEL_INV;
      cnt_q        <= 8'h00;
    end else begin
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      comm_bcd_q   <= comm_bcd_d;
      comm_dp_q    <= comm_dp_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      buf_q        <= buf_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state: shadow capture, frame commit, scan FSM and output recompute.
  always_comb begin
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    comm_bcd_d   = comm_bcd_q;
    comm_dp_d    = comm_dp_q;
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    buf_d        = buf_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    show_s       = 1'b0;

    if (bus.load) begin
      shadow_bcd_d = bus.digit_bcd;
      shadow_dp_d  = bus.dp_mask;
    end else begin
      shadow_bcd_d = shadow_bcd_q;
      shadow_dp_d  = shadow_dp_q;
    end

    if (bus.frame_tick) begin
      // A coincident load is not yet in shadow_q, so it waits one frame.
      comm_bcd_d = shadow_bcd_q;
      comm_dp_d  = shadow_dp_q;
      cnt_d      = cnt_q + 8'd1;
      case (state_q)
        ST_BLANK: begin
          show_s = 1'b0;
          if (!bus.blank) begin
            state_d = ST_SCAN;
            idx_d   = {IDX_W{1'b0}};
            hold_d  = {HOLD_W{1'b0}};
          end else begin
            state_d = ST_BLANK;
          end
        end
        ST_SCAN: begin
          if (bus.blank) begin
            show_s  = 1'b0;
            state_d = ST_BLANK;
            idx_d   = {IDX_W{1'b0}};
            hold_d  = {HOLD_W{1'b0}};
          end else begin
            show_s = 1'b1;
            if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
              hold_d = {HOLD_W{1'b0}};
              if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = {IDX_W{1'b0}};
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        default: begin
          show_s  = 1'b0;
          state_d = ST_BLANK;
          idx_d   = {IDX_W{1'b0}};
          hold_d  = {HOLD_W{1'b0}};
        end
      endcase
      // Digit enable stays on even when the decoder blanks the segments.
      buf_d = (show_s ? seg_s : SEG_OFF) ^ BUF_INV;
      sel_d = (show_s ? (NUM_DIGITS'(1) << idx_q) : {NUM_DIGITS{1'b0}}) ^ SEL_INV;
    end else begin
      comm_bcd_d = comm_bcd_q;
      comm_dp_d  = comm_dp_q;
    end
  end

  assign bus.o_buf       = buf_q;
  assign bus.o_digit_sel = sel_q;
  assign bus.o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_seg7_frame_feeder.sv
// -----------------------------------------------------------------------------
// tb_seg7_frame_feeder
// Three feeders share one stimulus: A (defaults), B (LZ_BLANK=0) and
// C (COMMON_ANODE=1). Table-driven vectors exercise decode/scan; hand-written
// sequences cover coincident load, blanking, reset and counter wrap.
// -----------------------------------------------------------------------------
module tb_seg7_frame_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] digit_bcd;
  logic [1:0] dp_mask;
  logic       blank;
  logic       load;
  logic       frame_tick;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_cnt  = 8'h00;

  always #5 clk = ~clk;

  seg7_frame_feeder_if #(.NUM_DIGITS(2)) if_a ();
  seg7_frame_feeder_if #(.NUM_DIGITS(2)) if_b ();
  seg7_frame_feeder_if #(.NUM_DIGITS(2)) if_c ();

  assign if_a.digit_bcd = digit_bcd;  assign if_b.digit_bcd = digit_bcd;  assign if_c.digit_bcd = digit_bcd;
  assign if_a.dp_mask = dp_mask;      assign if_b.dp_mask = dp_mask;      assign if_c.dp_mask = dp_mask;
  assign if_a.blank = blank;          assign if_b.blank = blank;          assign if_c.blank = blank;
  assign if_a.load = load;            assign if_b.load = load;            assign if_c.load = load;
  assign if_a.frame_tick = frame_tick; assign if_b.frame_tick = frame_tick; assign if_c.frame_tick = frame_tick;

  seg7_frame_feeder #(.NUM_DIGITS(2), .HOLD_FRAMES(4), .COMMON_ANODE(0), .LZ_BLANK(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  seg7_frame_feeder #(.NUM_DIGITS(2), .HOLD_FRAMES(4), .COMMON_ANODE(0), .LZ_BLANK(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  seg7_frame_feeder #(.NUM_DIGITS(2), .HOLD_FRAMES(4), .COMMON_ANODE(1), .LZ_BLANK(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  typedef struct {
    logic [7:0] bcd;
    logic [1:0] dp;
    logic [7:0] a0, a1;   // A: digit0 / digit1 byte
    logic [7:0] b0, b1;   // B: no leading-zero blanking
    logic [7:0] c0, c1;   // C: inverted bytes
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; pulses frame_tick across exactly one posedge.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic do_load(input logic [7:0] v, input logic [1:0] dp);
    digit_bcd = v;
    dp_mask   = dp;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  logic [7:0] prev_buf_a, prev_buf_c;
  logic [1:0] prev_sel_a, prev_sel_c;
  logic       tk, d1;

  initial begin
    vecs[0] = '{8'h25, 2'b00, 8'h6D, 8'h5B, 8'h6D, 8'h5B, 8'h92, 8'hA4};
    vecs[1] = '{8'h07, 2'b00, 8'h07, 8'h00, 8'h07, 8'h3F, 8'hF8, 8'hFF};
    vecs[2] = '{8'hA3, 2'b00, 8'h4F, 8'h40, 8'h4F, 8'h40, 8'hB0, 8'hBF};
    vecs[3] = '{8'hA3, 2'b01, 8'hCF, 8'h40, 8'hCF, 8'h40, 8'h30, 8'hBF};
    vecs[4] = '{8'h88, 2'b00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80};
    vecs[5] = '{8'h00, 2'b10, 8'h3F, 8'h80, 8'h3F, 8'hBF, 8'hC0, 8'h7F};
    vecs[6] = '{8'h9F, 2'b00, 8'h40, 8'h6F, 8'h40, 8'h6F, 8'hBF, 8'h90};
    vecs[7] = '{8'h0B, 2'b00, 8'h40, 8'h00, 8'h40, 8'h3F, 8'hBF, 8'hFF};
    vecs[8] = '{8'hB0, 2'b00, 8'h3F, 8'h40, 8'h3F, 8'h40, 8'hC0, 8'hBF};

    rst_n = 1'b0; digit_bcd = 8'h00; dp_mask = 2'b00;
    blank = 1'b1; load = 1'b0; frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_buf_a", if_a.o_buf, 8'h00);
    check("rst_sel_a", 8'(if_a.o_digit_sel), 8'h00);
    check("rst_cnt_a", if_a.o_frame_cnt, 8'h00);
    check("rst_buf_c", if_c.o_buf, 8'hFF);
    check("rst_sel_c", 8'(if_c.o_digit_sel), 8'h03);

    // Frame counter wrap
    repeat (255) tick();
    check("cnt_ff", if_a.o_frame_cnt, 8'hFF);
    tick();
    check("cnt_wrap", if_a.o_frame_cnt, 8'h00);
    check("cnt_wrap_model", if_a.o_frame_cnt, exp_cnt);

    // Table-driven decode and scan
    for (int v = 0; v < 9; v++) begin
      blank = 1'b1; tick();
      do_load(vecs[v].bcd, vecs[v].dp);
      check("load_no_change", if_a.o_buf, 8'h00);
      blank = 1'b0; tick();
      check("xfer_frame_off", if_a.o_buf, 8'h00);
      for (int k = 1; k <= 9; k++) begin
        tick();
        d1 = (((k - 1) / 4) % 2) == 1;
        check($sformatf("v%0d_k%0d_buf_a", v, k), if_a.o_buf, d1 ? vecs[v].a1 : vecs[v].a0);
        check($sformatf("v%0d_k%0d_sel_a", v, k), 8'(if_a.o_digit_sel), d1 ? 8'h02 : 8'h01);
        if (k == 1 || k == 5) begin
          check($sformatf("v%0d_k%0d_buf_b", v, k), if_b.o_buf, d1 ? vecs[v].b1 : vecs[v].b0);
          check($sformatf("v%0d_k%0d_buf_c", v, k), if_c.o_buf, d1 ? vecs[v].c1 : vecs[v].c0);
          check($sformatf("v%0d_k%0d_sel_c", v, k), 8'(if_c.o_digit_sel), d1 ? 8'h01 : 8'h02);
        end
      end
    end
    check("cnt_after_table", if_a.o_frame_cnt, exp_cnt);

    // load coincident with frame_tick: old value this frame, new one next
    blank = 1'b1; tick();
    do_load(8'h07, 2'b00);
    blank = 1'b0; tick();
    digit_bcd = 8'h25; dp_mask = 2'b00; load = 1'b1;
    tick();
    load = 1'b0;
    check("coinc_old", if_a.o_buf, 8'h07);
    tick();
    check("coinc_new", if_a.o_buf, 8'h6D);

    // blank mid-hold, then restart from digit0 with a fresh hold
    tick();
    blank = 1'b1; tick();
    check("blank_buf_a", if_a.o_buf, 8'h00);
    check("blank_sel_a", 8'(if_a.o_digit_sel), 8'h00);
    check("blank_buf_c", if_c.o_buf, 8'hFF);
    check("blank_sel_c", 8'(if_c.o_digit_sel), 8'h03);
    blank = 1'b0; tick();
    check("unblank_off", if_a.o_buf, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("restart_k%0d_buf", k), if_a.o_buf, (k == 5) ? 8'h5B : 8'h6D);
      check($sformatf("restart_k%0d_sel", k), 8'(if_a.o_digit_sel), (k == 5) ? 8'h02 : 8'h01);
    end

    // Random traffic: outputs may only move on a frame_tick
    for (int i = 0; i < 2000; i++) begin
      prev_buf_a = if_a.o_buf;  prev_sel_a = if_a.o_digit_sel;
      prev_buf_c = if_c.o_buf;  prev_sel_c = if_c.o_digit_sel;
      tk = ($urandom_range(0, 4) == 0);
      frame_tick = tk;
      load = ($urandom_range(0, 9) == 0);
      digit_bcd = 8'($urandom_range(0, 255));
      dp_mask = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) blank = ~blank;
      @(negedge clk);
      frame_tick = 1'b0; load = 1'b0;
      if (tk) exp_cnt = exp_cnt + 8'd1;
      check("rand_cnt", if_a.o_frame_cnt, exp_cnt);
      if (!tk) begin
        check("stable_buf_a", if_a.o_buf, prev_buf_a);
        check("stable_sel_a", 8'(if_a.o_digit_sel), 8'(prev_sel_a));
        check("stable_buf_c", if_c.o_buf, prev_buf_c);
        check("stable_sel_c", 8'(if_c.o_digit_sel), 8'(prev_sel_c));
      end
    end

    // Reset mid-scan: immediate return to off, tick during reset ignored
    blank = 1'b0;
    do_load(8'h25, 2'b00);
    tick(); tick(); tick();
    check("pre_rst_scan", if_a.o_buf, 8'h6D);
    rst_n = 1'b0;
    #1;
    check("rst_mid_buf_a", if_a.o_buf, 8'h00);
    check("rst_mid_sel_a", 8'(if_a.o_digit_sel), 8'h00);
    check("rst_mid_buf_c", if_c.o_buf, 8'hFF);
    check("rst_mid_sel_c", 8'(if_c.o_digit_sel), 8'h03);
    check("rst_mid_cnt", if_a.o_frame_cnt, 8'h00);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    rst_n = 1'b1;
    exp_cnt = 8'h00;
    @(negedge clk);
    check("rst_tick_ignored", if_a.o_frame_cnt, 8'h00);
    tick();
    check("post_rst_off", if_a.o_buf, 8'h00);
    tick();
    check("post_rst_shadow0", if_a.o_buf, 8'h3F);
    check("post_rst_cnt", if_a.o_frame_cnt, exp_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
